// File: rtl/scroll_pkg.sv
// Shared constants and the digit-shift helper for the scrolling banner register.
package scroll_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [0:0] PAUSE = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  // Widest digit string the helper supports (W*N must not exceed this).
  localparam int unsigned SCROLL_MAXB = 256;

  typedef logic [SCROLL_MAXB-1:0] scroll_vec_t;

  // One-digit shift of a w*n-bit string held in the low bits of data.
  // blank carries the fill digit in its low w bits.
  function automatic scroll_vec_t shift_digits(
    input scroll_vec_t data,
    input logic        dir,
    input logic        rot,
    input scroll_vec_t blank,
    input int unsigned w,
    input int unsigned n
  );
    scroll_vec_t all_ones;
    scroll_vec_t tmask;
    scroll_vec_t wmask;
    scroll_vec_t d;
    scroll_vec_t fill;
    scroll_vec_t res;
    int unsigned total;
    total    = w * n;
    all_ones = '1;
    tmask    = ~(all_ones << total);
    wmask    = ~(all_ones << w);
    d        = data & tmask;
    if (dir == DIR_RIGHT) begin
      fill = (rot ? d : blank) & wmask;
      res  = (d >> w) | (fill << (total - w));
    end else begin
      fill = (rot ? (d >> (total - w)) : blank) & wmask;
      res  = (d << w) | fill;
    end
    return res & tmask;
  endfunction

endpackage

// File: rtl/scroll_prescaler.sv
// Scroll-rate prescaler: ticks when the count reaches the live period, then restarts.
module scroll_prescaler
  import scroll_pkg::*;
#(
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enable,
  input  logic          i_clear,
  input  logic [PW-1:0] i_period,
  output logic          o_tick
);

  logic [PW-1:0] r_cnt;
  logic          w_tick;

  // >= so that lowering the period below the current count fires at once.
  assign w_tick = i_enable & (r_cnt >= i_period);
  assign o_tick = w_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (w_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/scroll_digit_register.sv
// N-digit scrolling banner register: parallel load, serial push, timed or stepped shifts.
module scroll_digit_register
  import scroll_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned N     = 6,
  parameter int unsigned PW    = 16,
  parameter logic [W-1:0] BLANK = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W*N-1:0] data_in,
  input  logic           write,
  input  logic           push_valid,
  input  logic [W-1:0]   push_digit,
  output logic           push_ready,
  input  logic           start,
  input  logic           pause,
  input  logic           step,
  input  logic           set_left,
  input  logic           set_right,
  input  logic           rotate,
  input  logic [PW-1:0]  period,
  output logic [W*N-1:0] data_out,
  output logic           running,
  output logic           wrap
);

  localparam int unsigned DW   = W * N;
  localparam int unsigned POSW = $clog2(N);
  localparam logic [POSW-1:0] LAST_POS = POSW'(N - 1);

  logic [0:0]      r_state;
  logic            r_dir;
  logic [DW-1:0]   r_data;
  logic [POSW-1:0] r_pos;
  logic            r_wrap;

  logic [0:0]    w_state_nxt;
  logic          w_push_fire;
  logic          w_load;
  logic          w_enter_run;
  logic          w_leave_run;
  logic          w_shift_req;
  logic          w_do_shift;
  logic          w_pre_clear;
  logic          w_tick;
  logic          w_last_pos;
  logic [DW-1:0] w_shifted;

  scroll_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_enable (r_state == RUN),
    .i_clear  (w_pre_clear),
    .i_period (period),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_push_fire = push_valid & ~write;
    w_load      = write | w_push_fire;
    w_enter_run = (r_state == PAUSE) & start & ~pause;
    w_leave_run = (r_state == RUN) & pause;
    w_shift_req = (r_state == PAUSE) ? step : (~pause & w_tick);
    // A load or push on the same edge drops the shift rather than deferring it.
    w_do_shift  = w_shift_req & ~w_load;
    w_pre_clear = w_load | w_enter_run | w_leave_run;
    w_last_pos  = (r_pos == LAST_POS);
    w_shifted   = DW'(shift_digits(SCROLL_MAXB'(r_data), r_dir, rotate,
                                   SCROLL_MAXB'(BLANK), W, N));
    w_state_nxt = r_state;
    if (w_enter_run)      w_state_nxt = RUN;
    else if (w_leave_run) w_state_nxt = PAUSE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PAUSE;
      r_dir   <= DIR_RIGHT;
      r_data  <= '0;
      r_pos   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (set_left)       r_dir <= DIR_LEFT;
      else if (set_right) r_dir <= DIR_RIGHT;

      if (write)            r_data <= data_in;
      else if (w_push_fire) r_data <= {r_data[DW-W-1:0], push_digit};
      else if (w_do_shift)  r_data <= w_shifted;

      if (w_load || w_enter_run)  r_pos <= '0;
      else if (w_do_shift)        r_pos <= w_last_pos ? '0 : r_pos + POSW'(1);

      r_wrap <= w_do_shift & w_last_pos;
    end
  end

  assign push_ready = ~write;
  assign data_out   = r_data;
  assign running    = (r_state == RUN);
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_scroll_digit_register.sv
// Scoreboard bench for scroll_digit_register: stimulus queues expectations, monitor compares.
module tb_scroll_digit_register;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] data_in;
  logic        write, push_valid, push_ready;
  logic [3:0]  push_digit;
  logic        start, pause, step, set_left, set_right, rotate;
  logic [15:0] period;
  logic [23:0] data_out;
  logic        running, wrap;

  scroll_digit_register #(
    .W     (4),
    .N     (6),
    .PW    (16),
    .BLANK (4'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .write      (write),
    .push_valid (push_valid),
    .push_digit (push_digit),
    .push_ready (push_ready),
    .start      (start),
    .pause      (pause),
    .step       (step),
    .set_left   (set_left),
    .set_right  (set_right),
    .rotate     (rotate),
    .period     (period),
    .data_out   (data_out),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [23:0] d;
    logic        run;
    logic        wr;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endfunction

  // Monitor: after every edge, compare every expectation stamped for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) check({e.name, "_stamp"}, e.cyc, cyc);
        check({e.name, "_data"}, {8'h0, data_out}, {8'h0, e.d});
        check({e.name, "_run"}, {31'h0, running}, {31'h0, e.run});
        check({e.name, "_wrap"}, {31'h0, wrap}, {31'h0, e.wr});
      end
    end
  end

  task automatic idle_strobes();
    write = 1'b0; push_valid = 1'b0; start = 1'b0; pause = 1'b0;
    step = 1'b0; set_left = 1'b0; set_right = 1'b0;
  endtask

  task automatic edge_exp(input string nm, input logic [23:0] d, input logic r, input logic w);
    exp_t e;
    e.cyc = cyc + 1; e.name = nm; e.d = d; e.run = r; e.wr = w;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    idle_strobes();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rot_tbl [6];
    logic [23:0] run_tbl [8];
    rot_tbl = '{24'h612345, 24'h561234, 24'h456123, 24'h345612, 24'h234561, 24'h123456};
    run_tbl = '{24'h123456, 24'h123456, 24'h012345, 24'h012345,
                24'h012345, 24'h001234, 24'h001234, 24'h001234};
    reset = 1'b1; data_in = '0; push_digit = '0; rotate = 1'b0; period = '0;
    idle_strobes();
    @(negedge clk); @(negedge clk);
    check("rst_data", {8'h0, data_out}, 32'h0);
    check("rst_run", {31'h0, running}, 32'h0);
    check("rst_wrap", {31'h0, wrap}, 32'h0);
    check("rst_pready", {31'h0, push_ready}, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    // Rotate right at period 0, full revolution with wrap.
    data_in = 24'h123456; write = 1'b1; set_right = 1'b1;
    edge_exp("s1_load", 24'h123456, 1'b0, 1'b0);
    rotate = 1'b1; period = 16'd0; start = 1'b1;
    edge_exp("s1_start", 24'h123456, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) edge_exp("s1_rot", rot_tbl[i], 1'b1, (i == 5));
    edge_exp("s1_after", 24'h612345, 1'b1, 1'b0);
    pause = 1'b1;
    edge_exp("s1_pause", 24'h612345, 1'b0, 1'b0);

    // Logical left single steps in PAUSE.
    rotate = 1'b0; data_in = 24'h123456; write = 1'b1; set_left = 1'b1;
    edge_exp("s2_load", 24'h123456, 1'b0, 1'b0);
    step = 1'b1;
    edge_exp("s2_step1", 24'h234560, 1'b0, 1'b0);
    step = 1'b1;
    edge_exp("s2_step2", 24'h345600, 1'b0, 1'b0);
    edge_exp("s2_hold", 24'h345600, 1'b0, 1'b0);

    // Period 2: shift every third edge; pause on a tick edge.
    data_in = 24'h123456; write = 1'b1; set_right = 1'b1; period = 16'd2;
    edge_exp("s3_load", 24'h123456, 1'b0, 1'b0);
    start = 1'b1;
    edge_exp("s3_start", 24'h123456, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) edge_exp("s3_run", run_tbl[i], 1'b1, 1'b0);
    pause = 1'b1;
    edge_exp("s3_pause", 24'h001234, 1'b0, 1'b0);
    edge_exp("s3_held", 24'h001234, 1'b0, 1'b0);

    // Lowering period below the running count shifts on the next edge.
    period = 16'd5; start = 1'b1;
    edge_exp("s3b_start", 24'h001234, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) edge_exp("s3b_count", 24'h001234, 1'b1, 1'b0);
    period = 16'd1;
    edge_exp("s3b_lower", 24'h000123, 1'b1, 1'b0);
    edge_exp("s3b_cnt", 24'h000123, 1'b1, 1'b0);
    edge_exp("s3b_tick", 24'h000012, 1'b1, 1'b0);
    pause = 1'b1;
    edge_exp("s3b_pause", 24'h000012, 1'b0, 1'b0);

    // Serial push, then push colliding with write.
    data_in = 24'h123456; write = 1'b1;
    edge_exp("s4_load", 24'h123456, 1'b0, 1'b0);
    push_valid = 1'b1; push_digit = 4'hA;
    #1 check("s4_pready1", {31'h0, push_ready}, 32'h1);
    edge_exp("s4_push", 24'h23456A, 1'b0, 1'b0);
    push_valid = 1'b1; push_digit = 4'h7; write = 1'b1; data_in = 24'hFEDCBA;
    #1 check("s4_pready0", {31'h0, push_ready}, 32'h0);
    edge_exp("s4_collide", 24'hFEDCBA, 1'b0, 1'b0);
    edge_exp("s4_hold", 24'hFEDCBA, 1'b0, 1'b0);

    // Write on a tick edge in RUN, then simultaneous direction strobes.
    rotate = 1'b1; period = 16'd0; start = 1'b1;
    edge_exp("s5_start", 24'hFEDCBA, 1'b1, 1'b0);
    edge_exp("s5_shift", 24'hAFEDCB, 1'b1, 1'b0);
    data_in = 24'hABCDEF; write = 1'b1;
    edge_exp("s5_write", 24'hABCDEF, 1'b1, 1'b0);
    edge_exp("s5_next", 24'hFABCDE, 1'b1, 1'b0);
    set_left = 1'b1; set_right = 1'b1;
    edge_exp("s5_olddir", 24'hEFABCD, 1'b1, 1'b0);
    edge_exp("s5_left1", 24'hFABCDE, 1'b1, 1'b0);
    edge_exp("s5_left2", 24'hABCDEF, 1'b1, 1'b0);

    // Asynchronous reset between edges while scrolling.
    #2 reset = 1'b1;
    #1;
    check("s6_rst_data", {8'h0, data_out}, 32'h0);
    check("s6_rst_run", {31'h0, running}, 32'h0);
    check("s6_rst_wrap", {31'h0, wrap}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    data_in = 24'h123456; write = 1'b1;
    edge_exp("s6_load", 24'h123456, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) edge_exp("s6_still", 24'h123456, 1'b0, 1'b0);
    step = 1'b1;
    edge_exp("s6_step_right", 24'h612345, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
